// File: rtl/mips_pkg.sv
// Shared encodings and control types for the single-cycle MIPS subset core.
package mips_pkg;

   localparam int NUM_REGS = 32;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ADD,
      SUB,
      AND,
      OR,
      SLT
   } alu_op_t;

   typedef struct packed {
      logic    reg_write;
      logic    reg_dst;
      logic    alu_src;
      logic    mem_write;
      logic    mem_to_reg;
      logic    branch;
      logic    jump;
      alu_op_t alu_op;
   } ctrl_t;

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port,
// r0 hardwired to zero.
module mips_regfile (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  i_ra1,
   input  logic [4:0]  i_ra2,
   input  logic        i_we,
   input  logic [4:0]  i_wa,
   input  logic [31:0] i_wd,
   output logic [31:0] o_rd1,
   output logic [31:0] o_rd2
);
   import mips_pkg::*;

   logic [31:0] r_regs [NUM_REGS] = '{default: '0};

   // NOTE: non-blocking assignments commit on the edge, so a read of the register being written this cycle still returns the old value.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we && (i_wa != 5'd0)) begin
         r_regs[i_wa] <= i_wd;
      end
   end

   assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : r_regs[i_ra1];
   assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : r_regs[i_ra2];

endmodule

// File: rtl/mips_cpu.sv
// Single-cycle MIPS subset core: fetch, decode, execute, memory and writeback resolve
// within one cycle; pc, registers and data RAM update on the rising edge.
module mips_cpu #(
   parameter int IMEM_WORDS = 64,
   parameter int DMEM_WORDS = 64
) (
   input logic clk,
   input logic reset
);
   import mips_pkg::*;

   localparam int IMEM_AW = $clog2(IMEM_WORDS);
   localparam int DMEM_AW = $clog2(DMEM_WORDS);

   logic [31:0] r_pc = '0;
   logic [31:0] r_imem [IMEM_WORDS] = '{default: '0};
   logic [31:0] r_dmem [DMEM_WORDS] = '{default: '0};

   logic [31:0]        w_instr;
   logic [31:0]        w_pc_plus4;
   logic [31:0]        w_pc_next;
   logic [31:0]        w_simm;
   logic [31:0]        w_rd1;
   logic [31:0]        w_rd2;
   logic [31:0]        w_alu_b;
   logic [31:0]        w_alu_y;
   logic [31:0]        w_wb_data;
   logic [5:0]         w_op;
   logic [5:0]         w_funct;
   logic [4:0]         w_rs;
   logic [4:0]         w_rt;
   logic [4:0]         w_rd;
   logic [4:0]         w_wa;
   logic [IMEM_AW-1:0] w_imem_idx;
   logic [DMEM_AW-1:0] w_dmem_idx;
   logic               w_take_branch;
   ctrl_t              w_ctrl;

   assign w_imem_idx = r_pc[IMEM_AW+1:2];
   assign w_instr    = r_imem[w_imem_idx];
   assign w_op       = w_instr[31:26];
   assign w_rs       = w_instr[25:21];
   assign w_rt       = w_instr[20:16];
   assign w_rd       = w_instr[15:11];
   assign w_funct    = w_instr[5:0];
   assign w_simm     = {{16{w_instr[15]}}, w_instr[15:0]};
   assign w_pc_plus4 = r_pc + 32'd4;

   // NOTE: every field gets a default before the case, so no path leaves a control bit unassigned and no latch is inferred.
   always_comb begin
      w_ctrl = '0;
      case (w_op)
         OP_RTYPE: begin
            w_ctrl.reg_dst   = 1'b1;
            w_ctrl.reg_write = 1'b1;
            case (w_funct)
               F_ADD:   w_ctrl.alu_op = ADD;
               F_SUB:   w_ctrl.alu_op = SUB;
               F_AND:   w_ctrl.alu_op = AND;
               F_OR:    w_ctrl.alu_op = OR;
               F_SLT:   w_ctrl.alu_op = SLT;
               default: w_ctrl.reg_write = 1'b0;
            endcase
         end
         OP_ADDI: begin
            w_ctrl.reg_write = 1'b1;
            w_ctrl.alu_src   = 1'b1;
         end
         OP_LW: begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.alu_src    = 1'b1;
            w_ctrl.mem_to_reg = 1'b1;
         end
         OP_SW: begin
            w_ctrl.alu_src   = 1'b1;
            w_ctrl.mem_write = 1'b1;
         end
         OP_BEQ:  w_ctrl.branch = 1'b1;
         OP_J:    w_ctrl.jump   = 1'b1;
         default: ;
      endcase
   end

   mips_regfile u_regfile (
      .clk   (clk),
      .reset (reset),
      .i_ra1 (w_rs),
      .i_ra2 (w_rt),
      .i_we  (w_ctrl.reg_write),
      .i_wa  (w_wa),
      .i_wd  (w_wb_data),
      .o_rd1 (w_rd1),
      .o_rd2 (w_rd2)
   );

   assign w_alu_b = w_ctrl.alu_src ? w_simm : w_rd2;

   always_comb begin
      case (w_ctrl.alu_op)
         ADD:     w_alu_y = w_rd1 + w_alu_b;
         SUB:     w_alu_y = w_rd1 - w_alu_b;
         AND:     w_alu_y = w_rd1 & w_alu_b;
         OR:      w_alu_y = w_rd1 | w_alu_b;
         SLT:     w_alu_y = {31'd0, $signed(w_rd1) < $signed(w_alu_b)};
         default: w_alu_y = '0;
      endcase
   end

   // Byte offset bits are ignored; the word index wraps over the RAM depth.
   assign w_dmem_idx = w_alu_y[DMEM_AW+1:2];
   assign w_wb_data  = w_ctrl.mem_to_reg ? r_dmem[w_dmem_idx] : w_alu_y;
   assign w_wa       = w_ctrl.reg_dst ? w_rd : w_rt;

   assign w_take_branch = w_ctrl.branch && (w_rd1 == w_rd2);

   always_comb begin
      w_pc_next = w_pc_plus4;
      if (w_ctrl.jump) begin
         w_pc_next = {w_pc_plus4[31:28], w_instr[25:0], 2'b00};
      end else if (w_take_branch) begin
         w_pc_next = w_pc_plus4 + {w_simm[29:0], 2'b00};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc <= '0;
      end else begin
         r_pc <= w_pc_next;
      end
   end

   // NOTE: data RAM has no reset path: its contents must survive reset, and a cleared array could not map onto block RAM.
   always_ff @(posedge clk) begin
      if (!reset && w_ctrl.mem_write) begin
         r_dmem[w_dmem_idx] <= w_rd2;
      end
   end

endmodule

// File: tb/tb_mips_cpu.sv
// Self-checking bench for mips_cpu: directed programs plus random programs compared
// against an instruction-level reference model.
module tb_mips_cpu;

   localparam int IMEM_WORDS = 64;
   localparam int DMEM_WORDS = 64;
   localparam int N_PROGS    = 20;
   localparam int PROG_LEN   = 24;
   localparam int RUN_CYCLES = 40;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] m_imem [IMEM_WORDS];
   logic [31:0] m_dmem [DMEM_WORDS];
   logic [31:0] m_regs [32];
   logic [31:0] m_pc;
   logic [31:0] prog [$];

   mips_cpu #(
      .IMEM_WORDS (IMEM_WORDS),
      .DMEM_WORDS (DMEM_WORDS)
   ) dut (
      .clk   (clk),
      .reset (reset)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
      return {6'h00, rs, rt, rd, 5'd0, funct};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [25:0] target);
      return {6'h02, target};
   endfunction

   task automatic put(input logic [31:0] w);
      prog.push_back(w);
   endtask

   // Reference model: one architectural instruction per call, straight from the ISA rules.
   task automatic model_step();
      logic [31:0] ins, a, b, simm, npc, addr;
      logic [4:0]  rs, rt, rd;
      ins  = m_imem[(m_pc >> 2) % IMEM_WORDS];
      rs   = ins[25:21];
      rt   = ins[20:16];
      rd   = ins[15:11];
      a    = m_regs[rs];
      b    = m_regs[rt];
      simm = {{16{ins[15]}}, ins[15:0]};
      addr = a + simm;
      npc  = m_pc + 32'd4;
      case (ins[31:26])
         6'h00: begin
            case (ins[5:0])
               6'h20:   if (rd != 0) m_regs[rd] = a + b;
               6'h22:   if (rd != 0) m_regs[rd] = a - b;
               6'h24:   if (rd != 0) m_regs[rd] = a & b;
               6'h25:   if (rd != 0) m_regs[rd] = a | b;
               6'h2A:   if (rd != 0) m_regs[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               default: ;
            endcase
         end
         6'h08:   if (rt != 0) m_regs[rt] = addr;
         6'h23:   if (rt != 0) m_regs[rt] = m_dmem[(addr >> 2) % DMEM_WORDS];
         6'h2B:   m_dmem[(addr >> 2) % DMEM_WORDS] = b;
         6'h04:   if (a == b) npc = npc + (simm << 2);
         6'h02:   npc = {npc[31:28], ins[25:0], 2'b00};
         default: ;
      endcase
      m_pc = npc;
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) begin
         m_pc = '0;
         for (int r = 1; r < 32; r++) m_regs[r] = '0;
      end else begin
         model_step();
      end
      @(negedge clk);
   endtask

   task automatic load_prog();
      for (int i = 0; i < IMEM_WORDS; i++) begin
         m_imem[i]     = (i < prog.size()) ? prog[i] : 32'd0;
         dut.r_imem[i] = m_imem[i];
      end
   endtask

   task automatic restart();
      reset = 1'b1;
      load_prog();
      tick();
      reset = 1'b0;
   endtask

   task automatic check_state(input string tag);
      check($sformatf("%s_pc", tag), dut.r_pc, m_pc);
      for (int r = 1; r < 32; r++)
         check($sformatf("%s_r%0d", tag, r), dut.u_regfile.r_regs[r], m_regs[r]);
      for (int w = 0; w < DMEM_WORDS; w++)
         check($sformatf("%s_dmem%0d", tag, w), dut.r_dmem[w], m_dmem[w]);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      rs  = 5'($urandom_range(0, 7));
      rt  = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      imm = 16'($urandom);
      case ($urandom_range(0, 13))
         0:       return enc_r(rs, rt, rd, 6'h20);
         1:       return enc_r(rs, rt, rd, 6'h22);
         2:       return enc_r(rs, rt, rd, 6'h24);
         3:       return enc_r(rs, rt, rd, 6'h25);
         4:       return enc_r(rs, rt, rd, 6'h2A);
         5:       return enc_r(rs, rt, rd, 6'h3F);
         6, 7:    return enc_i(6'h08, rs, rt, imm);
         8:       return enc_i(6'h23, rs, rt, imm);
         9, 10:   return enc_i(6'h2B, rs, rt, imm);
         11:      return enc_i(6'h04, rs, rt, 16'($urandom_range(0, 6)) - 16'd3);
         12:      return enc_j(26'($urandom_range(0, PROG_LEN - 1)));
         default: return enc_i(($urandom_range(0, 1) != 0) ? 6'h3F : 6'h01, rs, rt, imm);
      endcase
   endfunction

   initial begin
      for (int i = 0; i < IMEM_WORDS; i++) m_imem[i] = '0;
      for (int i = 0; i < DMEM_WORDS; i++) m_dmem[i] = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_pc = '0;
      #1;

      // Power-up without reset
      check("t1_pc_init", dut.r_pc, 32'd0);
      prog.delete();
      put(enc_i(6'h08, 0, 1, 16'd5));
      put(enc_i(6'h08, 0, 2, 16'd7));
      put(enc_r(1, 2, 3, 6'h20));
      load_prog();
      repeat (3) tick();
      check("t1_r3", dut.u_regfile.r_regs[3], 32'd12);
      check("t1_pc", dut.r_pc, 32'd12);
      check_state("t1");

      // ALU functions with a negative operand
      prog.delete();
      put(enc_i(6'h08, 0, 1, 16'hFFFD));
      put(enc_r(1, 0, 4, 6'h2A));
      put(enc_r(0, 1, 5, 6'h22));
      put(enc_r(5, 1, 6, 6'h24));
      put(enc_r(5, 1, 7, 6'h25));
      restart();
      repeat (5) tick();
      check("t2_r4", dut.u_regfile.r_regs[4], 32'd1);
      check("t2_r5", dut.u_regfile.r_regs[5], 32'd3);
      check("t2_r6", dut.u_regfile.r_regs[6], 32'd1);
      check("t2_r7", dut.u_regfile.r_regs[7], 32'hFFFF_FFFF);
      check_state("t2");

      // Store followed immediately by load of the same word
      prog.delete();
      put(enc_i(6'h08, 0, 1, 16'h0055));
      put(enc_i(6'h2B, 0, 1, 16'd8));
      put(enc_i(6'h23, 0, 2, 16'd8));
      restart();
      repeat (3) tick();
      check("t3_dmem2", dut.r_dmem[2], 32'h55);
      check("t3_r2", dut.u_regfile.r_regs[2], 32'h55);
      check_state("t3");

      // Branch taken, branch not taken, jump
      prog.delete();
      put(enc_i(6'h04, 0, 0, 16'd2));
      put(32'd0);
      put(32'd0);
      put(enc_i(6'h08, 0, 1, 16'd1));
      put(enc_i(6'h04, 1, 2, 16'd5));
      put(enc_j(26'h10));
      restart();
      tick();
      check("t4_beq_taken_pc", dut.r_pc, 32'd12);
      tick();
      check("t4_addi_pc", dut.r_pc, 32'd16);
      tick();
      check("t4_beq_not_taken_pc", dut.r_pc, 32'd20);
      tick();
      check("t4_j_pc", dut.r_pc, 32'h40);
      check_state("t4");

      // r0 immutability, unknown opcode and unknown funct
      prog.delete();
      put(enc_i(6'h08, 0, 8, 16'd77));
      put(enc_i(6'h08, 0, 9, 16'd5));
      put(enc_i(6'h08, 0, 0, 16'd9));
      put(enc_r(0, 0, 8, 6'h20));
      put(enc_i(6'h3F, 0, 9, 16'h1234));
      put(enc_r(1, 2, 9, 6'h3F));
      restart();
      repeat (3) tick();
      check("t5_r0_store", dut.u_regfile.r_regs[0], 32'd0);
      check("t5_r8_before", dut.u_regfile.r_regs[8], 32'd77);
      tick();
      check("t5_r8", dut.u_regfile.r_regs[8], 32'd0);
      repeat (2) tick();
      check("t5_r9", dut.u_regfile.r_regs[9], 32'd5);
      check("t5_pc", dut.r_pc, 32'd24);
      check_state("t5");

      // Reset mid-run lands on a store: regs and pc clear, RAM keeps its data
      prog.delete();
      put(enc_i(6'h08, 1, 1, 16'd1));
      put(enc_i(6'h08, 2, 2, 16'd3));
      put(enc_i(6'h2B, 0, 1, 16'd12));
      put(enc_j(26'd0));
      restart();
      repeat (10) tick();
      check("t6_pc_run", dut.r_pc, 32'd8);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_pc_reset", dut.r_pc, 32'd0);
      for (int r = 1; r < 32; r++)
         check($sformatf("t6_r%0d_reset", r), dut.u_regfile.r_regs[r], 32'd0);
      check("t6_dmem3_kept", dut.r_dmem[3], 32'd2);
      tick();
      check("t6_pc_restart", dut.r_pc, 32'd4);
      check("t6_r1_restart", dut.u_regfile.r_regs[1], 32'd1);
      check_state("t6");

      // Random programs against the reference model
      for (int p = 0; p < N_PROGS; p++) begin
         prog.delete();
         for (int i = 0; i < PROG_LEN; i++) prog.push_back(rand_instr());
         restart();
         for (int c = 0; c < RUN_CYCLES; c++) begin
            tick();
            check($sformatf("rnd%0d_c%0d_pc", p, c), dut.r_pc, m_pc);
         end
         check_state($sformatf("rnd%0d", p));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
